chaos_decryptor: RTL and testbench

CHAOS_DECRYPTOR -- requirements
Module: chaos_decryptor

---
 rtl/chaos_decryptor.sv | 128 ++++++++++++
 tb/tb_chaos_decryptor.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaos_decryptor.sv
// Logistic-map stream decryptor: pixel = cipher ^ keystream ^ previous cipher,
// with the map advanced once per accepted pixel and a one-deep output register.
module chaos_decryptor #(
   parameter int          PRECISION = 32,
   parameter int          BIT_WIDTH = 8,
   parameter logic [31:0] R_COEF    = 32'hFF5C28F6,
   parameter int          WARMUP    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [PRECISION-1:0] seed,
   input  logic [BIT_WIDTH-1:0] iv,
   input  logic                 s_tvalid,
   input  logic [BIT_WIDTH-1:0] s_tdata,
   input  logic                 s_tlast,
   output logic                 s_tready,
   output logic                 m_tvalid,
   output logic [BIT_WIDTH-1:0] m_tdata,
   output logic                 m_tlast,
   input  logic                 m_tready,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_t;

   localparam int CNT_W = (WARMUP < 2) ? 1 : $clog2(WARMUP);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WARMUP == 0) ? 0 : WARMUP - 1);

   function automatic logic [PRECISION-1:0] alt_pattern();
      logic [PRECISION-1:0] pat;
      for (int i = 0; i < PRECISION; i++) pat[i] = (i % 2 == 0);
      return pat;
   endfunction

   localparam logic [PRECISION-1:0] ZERO_SUB = alt_pattern();

   // x*(1-x) in Q0.P, scaled by r in Q2.30; zero is replaced so the map never sticks.
   function automatic logic [PRECISION-1:0] map_step(input logic [PRECISION-1:0] xv);
      logic [PRECISION:0]        compl;
      logic [2*PRECISION:0]      prod;
      logic [PRECISION-1:0]      t;
      logic [PRECISION+31:0]     scaled;
      logic [PRECISION-1:0]      nx;
      compl  = {1'b1, {PRECISION{1'b0}}} - {1'b0, xv};
      prod   = {{(PRECISION+1){1'b0}}, xv} * {{PRECISION{1'b0}}, compl};
      t      = PRECISION'(prod >> PRECISION);
      scaled = {{PRECISION{1'b0}}, R_COEF} * {32'd0, t};
      nx     = scaled[PRECISION+29:30];
      if (nx == '0) nx = ZERO_SUB;
      return nx;
   endfunction

   state_t               state, next_state;
   logic [PRECISION-1:0] x, x_next;
   logic [BIT_WIDTH-1:0] chain;
   logic [CNT_W-1:0]     cnt;
   logic                 accept, out_hs;

   assign x_next = map_step(x);
   assign accept = s_tvalid && s_tready;
   assign out_hs = m_tvalid && m_tready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      s_tready   = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = (WARMUP == 0) ? RUN : WARM;
         end
         WARM: begin
            if (cnt == CNT_LAST) next_state = RUN;
         end
         RUN: begin
            s_tready = !m_tvalid || m_tready;
            if (s_tvalid && s_tready && s_tlast) next_state = DRAIN;
         end
         DRAIN: begin
            if (out_hs) begin
               frame_done = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // keystream state, chaining value and the output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x        <= '0;
         chain    <= '0;
         cnt      <= '0;
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            x     <= seed;
            chain <= iv;
            cnt   <= '0;
         end
         if (state == WARM) begin
            x   <= x_next;
            cnt <= cnt + CNT_W'(1);
         end
         if (accept) begin
            m_tdata  <= s_tdata ^ x[BIT_WIDTH-1:0] ^ chain;
            m_tlast  <= s_tlast;
            m_tvalid <= 1'b1;
            chain    <= s_tdata;
            x        <= x_next;
         end else if (out_hs) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_chaos_decryptor.sv
// Bench for chaos_decryptor: known vectors plus randomized frames checked
// against a plain-arithmetic keystream/encryptor model.
module tb_chaos_decryptor;

   localparam int          WU = 1;
   localparam logic [31:0] RC = 32'hFF5C28F6;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] seed;
   logic [7:0]  iv;
   logic        s_tvalid;
   logic [7:0]  s_tdata;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tvalid;
   logic [7:0]  m_tdata;
   logic        m_tlast;
   logic        m_tready;
   logic        busy;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   chaos_decryptor #(
      .PRECISION(32), .BIT_WIDTH(8), .R_COEF(RC), .WARMUP(WU)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed), .iv(iv),
      .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // logistic map x' = r*x*(1-x), computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_step(input logic [31:0] xv);
      logic [63:0] xx, t, y;
      xx = {32'd0, xv};
      t  = (xx * (64'd4294967296 - xx)) >> 32;
      y  = ({32'd0, RC} * t) >> 30;
      if (y[31:0] == 32'd0) return 32'h55555555;
      return y[31:0];
   endfunction

   task automatic pulse_start(input logic [31:0] sd, input logic [7:0] ivv);
      @(negedge clk);
      start = 1'b1; seed = sd; iv = ivv; s_tvalid = 1'b0; m_tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input logic [31:0] sd, input logic [7:0] ivv, input int n,
                            input int stall_pct, input int gap_pct, input bit inject,
                            output int cycles);
      logic [7:0]  ks[$], plain[$], cipher[$];
      logic [31:0] xm;
      logic [7:0]  ch, hold_data;
      logic        hold_valid, hold_last, acc, ohs, injected;
      int sent, rcvd, cyc, budget;
      xm = sd;
      for (int i = 0; i < WU; i++) xm = ref_step(xm);
      ch = ivv;
      for (int i = 0; i < n; i++) begin
         ks.push_back(xm[7:0]);
         xm = ref_step(xm);
         plain.push_back(8'($urandom));
         cipher.push_back(plain[i] ^ ks[i] ^ ch);
         ch = cipher[i];
      end
      @(negedge clk);
      start = 1'b1; seed = sd; iv = ivv; s_tvalid = 1'b0; m_tready = 1'b1;
      sent = 0; rcvd = 0; cyc = 0; budget = n * 20 + 50;
      hold_valid = 1'b0; hold_data = '0; hold_last = 1'b0; injected = 1'b0;
      while (rcvd < n && cyc < budget) begin
         @(negedge clk);
         if (hold_valid) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== hold_data || m_tlast !== hold_last) begin
               failures++;
               $display("FAIL stall_hold: m_tvalid=%b m_tdata=%h m_tlast=%b required 1 %h %b",
                        m_tvalid, m_tdata, m_tlast, hold_data, hold_last);
            end
         end
         start = 1'b0;
         if (inject && !injected && sent == n / 2 && sent > 0) begin
            start = 1'b1; seed = $urandom; iv = 8'($urandom); injected = 1'b1;
         end
         m_tready = ($urandom_range(99) >= stall_pct);
         if (sent < n) begin
            s_tvalid = ($urandom_range(99) >= gap_pct);
            s_tdata  = cipher[sent];
            s_tlast  = (sent == n - 1);
         end else begin
            s_tvalid = 1'b0;
         end
         #1;
         if ((m_tvalid && !m_tready) || sent == n) begin
            checks++;
            if (s_tready !== 1'b0) begin
               failures++;
               $display("FAIL s_tready_blocked: s_tready=%b required 0 (sent=%0d)", s_tready, sent);
            end
         end
         ohs = m_tvalid && m_tready;
         acc = s_tvalid && s_tready;
         checks++;
         if (frame_done !== (ohs && rcvd == n - 1)) begin
            failures++;
            $display("FAIL frame_done: got %b required %b at pixel %0d", frame_done,
                     ohs && rcvd == n - 1, rcvd);
         end
         if (ohs) begin
            checks++;
            if (m_tdata !== plain[rcvd] || m_tlast !== (rcvd == n - 1)) begin
               failures++;
               $display("FAIL pixel_%0d: m_tdata=%h m_tlast=%b required %h %b", rcvd,
                        m_tdata, m_tlast, plain[rcvd], rcvd == n - 1);
            end
            rcvd++;
         end
         hold_valid = m_tvalid && !m_tready;
         hold_data  = m_tdata;
         hold_last  = m_tlast;
         if (acc) sent++;
         cyc++;
      end
      @(negedge clk);
      start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      #1;
      checks++;
      if (cyc >= budget || busy !== 1'b0 || m_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL frame_end: cycles=%0d busy=%b m_tvalid=%b rcvd=%0d required rcvd=%0d busy=0 m_tvalid=0",
                  cyc, busy, m_tvalid, rcvd, n);
      end
      cycles = cyc;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; seed = '0; iv = '0;
      s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({m_tvalid, m_tdata, m_tlast, s_tready, busy, frame_done} !== 12'd0) begin
         failures++;
         $display("FAIL reset_state: outputs=%h required 000",
                  {m_tvalid, m_tdata, m_tlast, s_tready, busy, frame_done});
      end
      reset = 1'b0;
      s_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (s_tready !== 1'b0 || busy !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_accept: s_tready=%b busy=%b m_tvalid=%b required 0 0 0",
                     s_tready, busy, m_tvalid);
         end
      end
      s_tvalid = 1'b0;
   endtask

   task automatic test_known_vector();
      pulse_start(32'h80000000, 8'h00);
      checks++;
      if (busy !== 1'b1 || s_tready !== 1'b0) begin
         failures++;
         $display("FAIL warm_state: busy=%b s_tready=%b required 1 0", busy, s_tready);
      end
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b1) begin
         failures++;
         $display("FAIL run_ready: s_tready=%b required 1", s_tready);
      end
      s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'hF6 || m_tlast !== 1'b1 || frame_done !== 1'b1) begin
         failures++;
         $display("FAIL known_vector: v=%b d=%h l=%b done=%b required 1 f6 1 1",
                  m_tvalid, m_tdata, m_tlast, frame_done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL known_vector_idle: busy=%b v=%b done=%b required 0 0 0",
                  busy, m_tvalid, frame_done);
      end
   endtask

   task automatic test_chain();
      logic [7:0] k1;
      k1 = ref_step(ref_step(32'h80000000))[7:0];
      pulse_start(32'h80000000, 8'h00);
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 8'hAA; s_tlast = 1'b0;
      @(negedge clk);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h5C || m_tlast !== 1'b0) begin
         failures++;
         $display("FAIL chain_p0: v=%b d=%h l=%b required 1 5c 0", m_tvalid, m_tdata, m_tlast);
      end
      s_tdata = 8'h3C; s_tlast = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++;
      if (m_tdata !== (8'h3C ^ k1 ^ 8'hAA) || m_tlast !== 1'b1) begin
         failures++;
         $display("FAIL chain_p1: d=%h l=%b required %h 1", m_tdata, m_tlast, 8'h3C ^ k1 ^ 8'hAA);
      end
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      int cyc;
      run_frame($urandom, 8'($urandom), 256, 0, 0, 1'b0, cyc);
      checks++;
      if (cyc !== 256 + WU + 1) begin
         failures++;
         $display("FAIL throughput: cycles=%0d required %0d", cyc, 256 + WU + 1);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      run_frame($urandom, 8'($urandom), 64, 40, 30, 1'b0, cyc);
      run_frame($urandom, 8'($urandom), 48, 60, 10, 1'b0, cyc);
   endtask

   task automatic test_zero_seed();
      int cyc;
      pulse_start(32'h0, 8'h00);
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b1;
      @(negedge clk);
      s_tvalid = 1'b0; s_tlast = 1'b0;
      checks++;
      if (m_tdata !== 8'h55 || m_tvalid !== 1'b1) begin
         failures++;
         $display("FAIL zero_seed: d=%h v=%b required 55 1", m_tdata, m_tvalid);
      end
      @(negedge clk);
      run_frame(32'h0, 8'($urandom), 32, 20, 20, 1'b1, cyc);
   endtask

   task automatic test_reset_midframe();
      int cyc;
      int w;
      pulse_start($urandom, 8'($urandom));
      w = 0;
      while (s_tready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      s_tvalid = 1'b1; s_tdata = 8'($urandom); s_tlast = 1'b0;
      @(negedge clk);
      s_tvalid = 1'b0; m_tready = 1'b0;
      #1;
      checks++;
      if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
         failures++;
         $display("FAIL midframe_setup: m_tvalid=%b s_tready=%b required 1 0", m_tvalid, s_tready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({m_tvalid, m_tdata, m_tlast, s_tready, busy, frame_done} !== 12'd0) begin
         failures++;
         $display("FAIL midframe_reset: outputs=%h required 000",
                  {m_tvalid, m_tdata, m_tlast, s_tready, busy, frame_done});
      end
      @(negedge clk);
      reset = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (s_tready !== 1'b0 || m_tvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: s_tready=%b m_tvalid=%b busy=%b required 0 0 0",
                     s_tready, m_tvalid, busy);
         end
      end
      s_tvalid = 1'b0;
      run_frame($urandom, 8'($urandom), 40, 25, 25, 1'b0, cyc);
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_chain();
      test_full_frame();
      test_back_to_back();
      test_zero_seed();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
